register_file_sb: RTL

Parametrised successor to the 4-entry CPU register file: `NUM_REGS` × `WIDTH` storage with two asynchronous read ports, one clocked write port, write-to-read bypass, and a per-register busy scoreboard for pipelined issue. It sits between the decode stage, which reads operands and reserves destinations, and the writeback stage, which commits results and releases reservations. An optional hardwired-zero register 0 is available.

---
 rtl/register_file_sb.sv | 110 +++++++++++
 1 files changed

// File: rtl/register_file_sb.sv
// Parametrised register file with two combinational read ports, one clocked write
// port, optional write-to-read bypass, optional hardwired-zero r0 and a busy scoreboard.
module register_file_sb #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        read1,
    input  logic [ADDR_W-1:0]        read2,
    output logic signed [WIDTH-1:0]  read_out1,
    output logic signed [WIDTH-1:0]  read_out2,
    output logic                     read_busy1,
    output logic                     read_busy2,
    input  logic [ADDR_W-1:0]        write_reg,
    input  logic signed [WIDTH-1:0]  write_data,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        reserve_reg,
    input  logic                     reserve,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [WIDTH-1:0]    reg_vals [NUM_REGS];
    logic [NUM_REGS-1:0] busy_all;

    genvar gi;

    // Per-register storage and busy bit.
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);

        logic             wr_hit;
        logic             rs_hit;
        logic [WIDTH-1:0] reg_q;
        logic [WIDTH-1:0] reg_d;
        logic             busy_q;
        logic             busy_d;

        assign wr_hit = reg_write && (write_reg == ADDR_W'(gi));
        assign rs_hit = reserve && (reserve_reg == ADDR_W'(gi));

        // Release then reserve: a new producer issued in the retiring cycle keeps the bit set.
        always_comb begin
            reg_d  = reg_q;
            busy_d = busy_q;
            if (wr_hit && !IS_ZERO) begin
                reg_d = write_data;
            end
            if (wr_hit) begin
                busy_d = 1'b0;
            end
            if (rs_hit) begin
                busy_d = 1'b1;
            end
            if (IS_ZERO) begin
                busy_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                reg_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                reg_q  <= reg_d;
                busy_q <= busy_d;
            end
        end

        assign reg_vals[gi] = reg_q;
        assign busy_all[gi] = busy_q;
    end

    logic [ADDR_W-1:0] rd_addr [2];
    logic [WIDTH-1:0]  rd_data [2];
    logic              rd_busy [2];

    assign rd_addr[0] = read1;
    assign rd_addr[1] = read2;

    // Read ports: zero register, then bypass of the in-flight write, then storage.
    for (gi = 0; gi < 2; gi++) begin : g_rd
        logic rd_fwd;

        assign rd_fwd = (BYPASS != 0) && !reset && reg_write && (write_reg == rd_addr[gi]);

        always_comb begin
            rd_data[gi] = reg_vals[rd_addr[gi]];
            if (rd_fwd) begin
                rd_data[gi] = write_data;
            end
            if ((ZERO_REG != 0) && (rd_addr[gi] == '0)) begin
                rd_data[gi] = '0;
            end
        end

        // A same-cycle commit only resolves the hazard when its data is forwarded.
        assign rd_busy[gi] = !reset && busy_all[rd_addr[gi]] && !rd_fwd;
    end

    assign read_out1  = rd_data[0];
    assign read_out2  = rd_data[1];
    assign read_busy1 = rd_busy[0];
    assign read_busy2 = rd_busy[1];
    assign busy_vec   = busy_all;

endmodule
